// File: rtl/srl_delay_line.sv
// Addressable shift-register delay line with a registered tap output, occupancy counter and data-valid flag.
// The sample storage has no reset so it can be mapped onto SRL primitives.
module srl_delay_line #(
   parameter int W  = 11,
   parameter int N  = 64,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  d,
   input  logic          ce,
   input  logic          flush,
   input  logic [AW-1:0] a,
   output logic [W-1:0]  y,
   output logic          vld,
   output logic          full,
   output logic [AW:0]   lvl
);

   // N is a power of two, so the saturation value is the top bit of lvl
   localparam logic [AW:0] LVL_MAX = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] LVL_ONE = {{AW{1'b0}}, 1'b1};

   logic [W-1:0] sr [0:N-1];
   logic [AW:0]  lvl_next;

   always_ff @(posedge clk) begin
      if (ce) begin
         sr[0] <= d;
         for (int i = 1; i < N; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   always_comb begin
      lvl_next = lvl;
      if (flush) begin
         lvl_next = ce ? LVL_ONE : '0;
      end else if (ce && (lvl != LVL_MAX)) begin
         lvl_next = lvl + LVL_ONE;
      end
   end

   // vld compares the tap against the occupancy seen before this edge's write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y    <= '0;
         vld  <= 1'b0;
         full <= 1'b0;
         lvl  <= '0;
      end else begin
         y    <= sr[a];
         vld  <= !flush && (lvl > {1'b0, a});
         full <= (lvl_next == LVL_MAX);
         lvl  <= lvl_next;
      end
   end

endmodule
